// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_pkg
// Purpose  : Shared AES-128 decryptor types, constants, S-box and round constants.
// Revision : 1.0 - initial release
// ============================================================================
package aes_pkg;

    localparam int AES_NR = 10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_KEYEXP = 3'd1,
        ST_ARK0   = 3'd2,
        ST_ROUNDS = 3'd3,
        ST_DONE   = 3'd4
    } aes_state_e;

    localparam logic [0:9][7:0] RCON = {
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[b];
    endfunction

    // Round counter runs 1..10; anything else yields zero.
    function automatic logic [7:0] get_rcon(input logic [3:0] r);
        logic [7:0] rc;
        rc = 8'h00;
        if (r >= 4'd1 && r <= 4'd10) begin
            rc = RCON[r - 4'd1];
        end
        return rc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_inv_round.sv
`default_nettype none
// ============================================================================
// Module   : aes_inv_round
// Purpose  : Combinational AES inverse round (InvShiftRows, InvSubBytes, ARK, InvMixColumns).
// Revision : 1.0 - initial release
// ============================================================================
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] rkey_i,
    input  logic         last_i,
    output logic [127:0] state_o
);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2[i] = xtime(a[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
            m9[i] = x8[i] ^ a[i];
            mb[i] = x8[i] ^ x2[i] ^ a[i];
            md[i] = x8[i] ^ x4[i] ^ a[i];
            me[i] = x8[i] ^ x4[i] ^ x2[i];
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    logic [127:0] w_ark;
    logic [127:0] w_mix;

    // Byte n of the block is row n%4 of column n/4; row r rotates right by r.
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int SRC = 4 * ((c - r + 4) % 4) + r;
            assign w_ark[127-8*(4*c+r) -: 8] =
                inv_sbox(state_i[127-8*SRC -: 8]) ^ rkey_i[127-8*(4*c+r) -: 8];
        end
        assign w_mix[127-32*c -: 32] = inv_mix_col(w_ark[127-32*c -: 32]);
    end

    assign state_o = last_i ? w_ark : w_mix;

endmodule
`default_nettype wire

// File: rtl/aes_decrypt.sv
`default_nettype none
// ============================================================================
// Module   : aes_decrypt
// Purpose  : Iterative AES-128 decryptor, one round per clock. Optional K10
//            key cache enabled by defining AES_DEC_KEYCACHE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module aes_decrypt
    import aes_pkg::*;
#(
    parameter int NR = AES_NR
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] cipher_text,
    input  logic [127:0] key,
    output logic [127:0] plaintext,
    output logic         ready,
    output logic         busy
);

    localparam logic [3:0] c_nr = 4'(NR);

    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n0 = k[127:96] ^ sub_rot(k[31:0]) ^ {rc, 24'h000000};
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0]  ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // Undo one expansion step: recover the previous round key from the current one.
    function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] p0, p1, p2, p3;
        p3 = k[31:0]  ^ k[63:32];
        p2 = k[63:32] ^ k[95:64];
        p1 = k[95:64] ^ k[127:96];
        p0 = k[127:96] ^ sub_rot(p3) ^ {rc, 24'h000000};
        return {p0, p1, p2, p3};
    endfunction

    aes_state_e   fsm_q;
    logic [127:0] state_q;
    logic [127:0] key_q;
    logic [3:0]   rnd_q;
    logic         ready_q;
    logic         busy_q;

    logic [7:0]   w_rcon;
    logic         w_last;
    logic [127:0] key_fwd_d;
    logic [127:0] key_inv_d;
    logic [127:0] round_d;

    assign w_rcon    = get_rcon(rnd_q);
    assign w_last    = (rnd_q == 4'd1);
    assign key_fwd_d = key_fwd(key_q, w_rcon);
    assign key_inv_d = key_inv(key_q, w_rcon);

    aes_inv_round u_inv_round (
        .state_i (state_q),
        .rkey_i  (key_inv_d),
        .last_i  (w_last),
        .state_o (round_d)
    );

`ifdef AES_DEC_KEYCACHE_EN
    logic         cache_vld_q;
    logic [127:0] cache_tag_q;
    logic [127:0] cache_k10_q;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm_q       <= ST_IDLE;
            state_q     <= '0;
            key_q       <= '0;
            rnd_q       <= 4'd0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
`ifdef AES_DEC_KEYCACHE_EN
            cache_vld_q <= 1'b0;
            cache_tag_q <= '0;
            cache_k10_q <= '0;
`endif
        end else begin
            case (fsm_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q <= cipher_text;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
`ifdef AES_DEC_KEYCACHE_EN
                        if (cache_vld_q && (key == cache_tag_q)) begin
                            key_q <= cache_k10_q;
                            rnd_q <= c_nr;
                            fsm_q <= ST_ARK0;
                        end else begin
                            key_q       <= key;
                            rnd_q       <= 4'd1;
                            fsm_q       <= ST_KEYEXP;
                            cache_vld_q <= 1'b0;
                            cache_tag_q <= key;
                        end
`else
                        key_q <= key;
                        rnd_q <= 4'd1;
                        fsm_q <= ST_KEYEXP;
`endif
                    end
                end
                ST_KEYEXP: begin
                    key_q <= key_fwd_d;
                    if (rnd_q == c_nr) begin
                        fsm_q <= ST_ARK0;
`ifdef AES_DEC_KEYCACHE_EN
                        cache_k10_q <= key_fwd_d;
                        cache_vld_q <= 1'b1;
`endif
                    end else begin
                        rnd_q <= rnd_q + 4'd1;
                    end
                end
                ST_ARK0: begin
                    state_q <= state_q ^ key_q;
                    rnd_q   <= c_nr;
                    fsm_q   <= ST_ROUNDS;
                end
                ST_ROUNDS: begin
                    state_q <= round_d;
                    key_q   <= key_inv_d;
                    rnd_q   <= rnd_q - 4'd1;
                    if (w_last) begin
                        fsm_q   <= ST_DONE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    fsm_q   <= ST_IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    rnd_q   <= 4'd0;
                end
            endcase
        end
    end

    assign plaintext = state_q;
    assign ready     = ready_q;
    assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_decrypt.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_decrypt
// Purpose  : Scoreboard bench for aes_decrypt using FIPS-197 vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_decrypt;

    localparam logic [127:0] c_k1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] c_c1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] c_p1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] c_k2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_c2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] c_p2 = 128'h3243f6a8885a308d313198a2e0370734;

    logic         clk;
    logic         reset;
    logic         start;
    logic [127:0] cipher_text;
    logic [127:0] key;
    logic [127:0] plaintext;
    logic         ready;
    logic         busy;

    typedef struct {
        logic [127:0] pt;
        int           accept;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   edge_cnt = 0;

`ifdef AES_DEC_KEYCACHE_EN
    logic         m_vld = 1'b0;
    logic [127:0] m_key = '0;
`endif

    aes_decrypt #(.NR(10)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .cipher_text (cipher_text),
        .key         (key),
        .plaintext   (plaintext),
        .ready       (ready),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [127:0] k);
`ifdef AES_DEC_KEYCACHE_EN
        int l;
        l = (m_vld && k == m_key) ? 11 : 21;
        m_vld = 1'b1;
        m_key = k;
        return l;
`else
        return (k === k) ? 21 : 21;
`endif
    endfunction

    task automatic push_exp(input logic [127:0] k, input logic [127:0] pt);
        exp_t e;
        e.pt     = pt;
        e.accept = edge_cnt + 1;
        e.lat    = exp_lat(k);
        sb.push_back(e);
    endtask

    // Drives start for one edge, then scrambles the inputs to prove they were captured.
    task automatic issue(input logic [127:0] k, input logic [127:0] ct, input logic [127:0] pt);
        @(negedge clk);
        key         = k;
        cipher_text = ct;
        start       = 1'b1;
        push_exp(k, pt);
        @(negedge clk);
        start       = 1'b0;
        key         = ~k;
        cipher_text = ~ct;
    endtask

    task automatic wait_ready(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready && n < budget);
        check("ready_arrives", {127'd0, ready}, 128'd1);
    endtask

    initial begin : monitor
        exp_t e;
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (ready && !prev) begin
                if (sb.size() == 0) begin
                    check("unexpected_ready", 128'd1, 128'd0);
                end else begin
                    e = sb.pop_front();
                    check("plaintext", plaintext, e.pt);
                    check_int("latency", edge_cnt - e.accept, e.lat);
                    check("busy_at_done", {127'd0, busy}, 128'd0);
                end
            end
            prev = ready;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        reset       = 1'b0;
        start       = 1'b0;
        key         = '0;
        cipher_text = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", {127'd0, ready}, 128'd0);
        check("rst_busy", {127'd0, busy}, 128'd0);
        check("rst_plaintext", plaintext, 128'd0);
        reset = 1'b1;
        @(negedge clk);
        check("idle_busy", {127'd0, busy}, 128'd0);

        // Test 1 with input scrambling after acceptance
        issue(c_k1, c_c1, c_p1);
        check("busy_after_start", {127'd0, busy}, 128'd1);
        wait_ready(40);

        // Test 3: start pulse sampled at edge 5 while busy is ignored
        issue(c_k1, c_c1, c_p1);
        repeat (4) @(negedge clk);
        cipher_text = 128'hdeadbeef_01234567_89abcdef_cafef00d;
        key         = c_k2;
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
        wait_ready(40);

        // Test 4: reset at edge 12 aborts, then a clean Test 2 run
        issue(c_k1, c_c1, c_p1);
        repeat (11) @(negedge clk);
        check("busy_mid_op", {127'd0, busy}, 128'd1);
        reset = 1'b0;
        #1;
        check("abort_ready", {127'd0, ready}, 128'd0);
        check("abort_busy", {127'd0, busy}, 128'd0);
        check("abort_plaintext", plaintext, 128'd0);
        void'(sb.pop_back());
`ifdef AES_DEC_KEYCACHE_EN
        m_vld = 1'b0;
`endif
        @(negedge clk);
        reset = 1'b1;
        issue(c_k2, c_c2, c_p2);
        wait_ready(40);

        // Test 2 standalone; result held while idle
        issue(c_k2, c_c2, c_p2);
        wait_ready(40);
        repeat (3) @(negedge clk);
        check("ready_held", {127'd0, ready}, 128'd1);
        check("plaintext_held", plaintext, c_p2);

        // Test 5: back-to-back restart from DONE with the same key
        issue(c_k1, c_c1, c_p1);
        wait_ready(40);
        issue(c_k1, c_c1, c_p1);
        wait_ready(40);

        // Test 6: start held across DONE restarts each run
        @(negedge clk);
        key         = c_k2;
        cipher_text = c_c2;
        start       = 1'b1;
        push_exp(c_k2, c_p2);
        for (int i = 0; i < 3; i++) begin
            wait_ready(40);
            if (i < 2) begin
                push_exp(c_k2, c_p2);
                @(negedge clk);
                check("restart_ready_drop", {127'd0, ready}, 128'd0);
            end else begin
                start = 1'b0;
                @(negedge clk);
                check("final_ready_hold", {127'd0, ready}, 128'd1);
            end
        end

        repeat (2) @(negedge clk);
        check_int("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
